// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button level in, debounced level and edge pulses out
interface button_debouncer_if;
    logic btn_in;
    logic btn_out;
    logic btn_rise;
    logic btn_fall;
    modport master (output btn_in, input btn_out, btn_rise, btn_fall);
    modport slave (input btn_in, output btn_out, btn_rise, btn_fall);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise and filter a bouncing button, emit clean level plus rise/fall pulses; BTN_DEBOUNCE_SYNC_EN selects a two-flop synchroniser
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    button_debouncer_if.slave bus
);
    typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic out_q, out_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic s;
`ifdef BTN_DEBOUNCE_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    // two-flop synchroniser: btn_in is asynchronous to clk
    always_comb begin
        sync1_d = bus.btn_in;
        sync2_d = sync1_q;
    end
    // synchroniser registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
    assign s = sync2_q;
`else
    logic sync_q, sync_d;
    // single sampling flop for inputs already synchronous to clk
    always_comb sync_d = bus.btn_in;
    // sampling register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 1'b0;
        else sync_q <= sync_d;
    end
    assign s = sync_q;
`endif
    // qualification FSM: a new level must hold for STABLE_CYCLES cycles; any return restarts it
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        out_d = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state_q)
            IDLE_LO: begin
                state_d = s ? WAIT_HI : IDLE_LO;
                cnt_d = s ? ONE : '0;
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d = '0;
                end else if (cnt_q == STABLE) begin
                    state_d = IDLE_HI;
                    cnt_d = '0;
                    out_d = 1'b1;
                    rise_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE_HI: begin
                state_d = s ? IDLE_HI : WAIT_LO;
                cnt_d = s ? '0 : ONE;
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d = '0;
                end else if (cnt_q == STABLE) begin
                    state_d = IDLE_LO;
                    cnt_d = '0;
                    out_d = 1'b0;
                    fall_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d = '0;
                out_d = 1'b0;
            end
        endcase
    end
    // FSM, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q <= '0;
            out_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign bus.btn_out = out_q;
    assign bus.btn_rise = rise_q;
    assign bus.btn_fall = fall_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of the debouncer with STABLE_CYCLES=4 and a second instance with STABLE_CYCLES=1
module tb_button_debouncer;
`ifdef BTN_DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif
    localparam int S = 4;
    localparam int LAT = S + SYNC_LAT;
    localparam int LAT1 = 1 + SYNC_LAT;
    logic clk;
    logic rst;
    int checks;
    int errors;
    button_debouncer_if bus ();
    button_debouncer_if bus1 ();
    button_debouncer #(.STABLE_CYCLES(S), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    button_debouncer #(.STABLE_CYCLES(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.btn_in = 1'b0;
        bus1.btn_in = 1'b0;
        #1;
        checks++;
        if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async out/rise/fall=%b required 000", {bus.btn_out, bus.btn_rise, bus.btn_fall});
        end
        repeat (3) tick;
        rst = 1'b0;
        repeat (3) tick;
        checks++;
        if ({bus.btn_out, bus.btn_rise, bus.btn_fall, bus1.btn_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle out/rise/fall/out1=%b required 0000", {bus.btn_out, bus.btn_rise, bus.btn_fall, bus1.btn_out});
        end
    endtask
    task automatic test_clean_press;
        bus.btn_in = 1'b1;
        for (int n = 1; n <= LAT + 4; n++) begin
            tick;
            checks++;
            if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== {n >= LAT + 1, n == LAT + 1, 1'b0}) begin
                errors++;
                $display("FAIL clean_press tick %0d out/rise/fall=%b required %b", n, {bus.btn_out, bus.btn_rise, bus.btn_fall}, {n >= LAT + 1, n == LAT + 1, 1'b0});
            end
        end
    endtask
    task automatic test_release;
        bus.btn_in = 1'b0;
        for (int n = 1; n <= LAT + 4; n++) begin
            tick;
            checks++;
            if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== {n < LAT + 1, 1'b0, n == LAT + 1}) begin
                errors++;
                $display("FAIL release tick %0d out/rise/fall=%b required %b", n, {bus.btn_out, bus.btn_rise, bus.btn_fall}, {n < LAT + 1, 1'b0, n == LAT + 1});
            end
        end
    endtask
    task automatic test_bounce_reject;
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 4; n++) begin
                bus.btn_in = (n < 3);
                tick;
                checks++;
                if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== 3'b000) begin
                    errors++;
                    $display("FAIL bounce_reject rep %0d tick %0d out/rise/fall=%b required 000", r, n, {bus.btn_out, bus.btn_rise, bus.btn_fall});
                end
            end
        end
        bus.btn_in = 1'b0;
        for (int n = 0; n < LAT + 3; n++) begin
            tick;
            checks++;
            if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== 3'b000) begin
                errors++;
                $display("FAIL bounce_tail tick %0d out/rise/fall=%b required 000", n, {bus.btn_out, bus.btn_rise, bus.btn_fall});
            end
        end
    endtask
    task automatic test_bounce_settle;
        bus.btn_in = 1'b1;
        tick;
        bus.btn_in = 1'b0;
        tick;
        tick;
        checks++;
        if ({bus.btn_out, bus.btn_rise} !== 2'b00) begin
            errors++;
            $display("FAIL glitch out/rise=%b required 00", {bus.btn_out, bus.btn_rise});
        end
        bus.btn_in = 1'b1;
        for (int n = 1; n <= LAT + 4; n++) begin
            tick;
            checks++;
            if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== {n >= LAT + 1, n == LAT + 1, 1'b0}) begin
                errors++;
                $display("FAIL settle tick %0d out/rise/fall=%b required %b", n, {bus.btn_out, bus.btn_rise, bus.btn_fall}, {n >= LAT + 1, n == LAT + 1, 1'b0});
            end
        end
    endtask
    task automatic test_async_reset_high;
        checks++;
        if (bus.btn_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_reset out=%b required 1", bus.btn_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_high out/rise/fall=%b required 000", {bus.btn_out, bus.btn_rise, bus.btn_fall});
        end
        bus.btn_in = 1'b0;
        tick;
        rst = 1'b0;
        for (int n = 0; n < LAT + 3; n++) begin
            tick;
            checks++;
            if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== 3'b000) begin
                errors++;
                $display("FAIL after_async_reset tick %0d out/rise/fall=%b required 000", n, {bus.btn_out, bus.btn_rise, bus.btn_fall});
            end
        end
    endtask
    task automatic test_reset_mid_wait;
        bus.btn_in = 1'b1;
        repeat (SYNC_LAT + 2) tick;
        checks++;
        if (dut.cnt_q !== 16'd2) begin
            errors++;
            $display("FAIL mid_wait_cnt cnt=%0d required 2", dut.cnt_q);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.btn_out, bus.btn_rise, bus.btn_fall, dut.cnt_q} !== {3'b000, 16'd0}) begin
            errors++;
            $display("FAIL mid_wait_reset out/rise/fall=%b cnt=%0d required 000 cnt 0", {bus.btn_out, bus.btn_rise, bus.btn_fall}, dut.cnt_q);
        end
        tick;
        rst = 1'b0;
        for (int n = 1; n <= LAT + 4; n++) begin
            tick;
            checks++;
            if ({bus.btn_out, bus.btn_rise, bus.btn_fall} !== {n >= LAT + 1, n == LAT + 1, 1'b0}) begin
                errors++;
                $display("FAIL post_reset_press tick %0d out/rise/fall=%b required %b", n, {bus.btn_out, bus.btn_rise, bus.btn_fall}, {n >= LAT + 1, n == LAT + 1, 1'b0});
            end
        end
    endtask
    task automatic test_stable_one;
        bus1.btn_in = 1'b1;
        tick;
        bus1.btn_in = 1'b0;
        for (int n = 0; n < LAT1 + 3; n++) begin
            tick;
            checks++;
            if ({bus1.btn_out, bus1.btn_rise} !== 2'b00) begin
                errors++;
                $display("FAIL s1_glitch tick %0d out/rise=%b required 00", n, {bus1.btn_out, bus1.btn_rise});
            end
        end
        bus1.btn_in = 1'b1;
        for (int n = 1; n <= LAT1 + 3; n++) begin
            tick;
            checks++;
            if ({bus1.btn_out, bus1.btn_rise, bus1.btn_fall} !== {n >= LAT1 + 1, n == LAT1 + 1, 1'b0}) begin
                errors++;
                $display("FAIL s1_press tick %0d out/rise/fall=%b required %b", n, {bus1.btn_out, bus1.btn_rise, bus1.btn_fall}, {n >= LAT1 + 1, n == LAT1 + 1, 1'b0});
            end
        end
    endtask
    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_clean_press;
        test_release;
        test_bounce_reject;
        test_bounce_settle;
        test_async_reset_high;
        test_reset_mid_wait;
        test_stable_one;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Upstream conditioning stage for the D flip-flop lab chain. Takes a raw, asynchronous, bouncing push-button or switch level and synchronises it to `clk`. Filters out any change that does not hold for a programmable number of cycles. Delivers a clean level plus one-cycle rise/fall pulses that can drive the flip-flop `d`/`clk` inputs or any counter stage.

## Interface
- `STABLE_CYCLES`, default 1000: consecutive cycles a new input value must hold before it is accepted; legal range 1..65535.
- `CNT_W`, default 16: counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_in`  in  1  raw button/switch level; asynchronous to `clk`, may bounce.
- `btn_out`  out  1  debounced level, registered.
- `btn_rise`  out  1  one-cycle pulse on accepted 0->1 transition, registered.
- `btn_fall`  out  1  one-cycle pulse on accepted 1->0 transition, registered.

## Operation
- Sample path: `btn_in` passes through the synchroniser (see Configuration); its output is `s`.
- FSM states: `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`. A counter `cnt` (CNT_W bits) runs alongside.
- `IDLE_LO`: `s`=1 -> `WAIT_HI`, `cnt`<=1; otherwise hold, `cnt`<=0.
- `WAIT_HI`:
  - `s`=0 -> `IDLE_LO`, `cnt`<=0, no output change (bounce rejected).
  - `s`=1 and `cnt`==STABLE_CYCLES -> `IDLE_HI`, `btn_out`<=1, `btn_rise`<=1, `cnt`<=0.
  - Otherwise `cnt`<=`cnt`+1.
- `IDLE_HI` / `WAIT_LO`: mirror images of the above with the values inverted; acceptance sets `btn_out`<=0 and `btn_fall`<=1.
- `btn_rise`/`btn_fall` are cleared on every edge where the acceptance condition is not met, so each is high for exactly one cycle. They are never high at the same time.
- `cnt` never exceeds STABLE_CYCLES and never wraps.
- `btn_out` changes only on acceptance and always equals the FSM level (`IDLE_HI`/`WAIT_LO` => 1).

## Timing
- Reset (async assert, released synchronously by the next `clk` edge): synchroniser flops 0, state `IDLE_LO`, `cnt`=0, `btn_out`=0, `btn_rise`=0, `btn_fall`=0.
- Latency, with the macro: new `btn_in` value first captured at edge k and held steadily -> `btn_out` and the pulse update at edge k+STABLE_CYCLES+2.
- Latency, without the macro: edge k+STABLE_CYCLES+1.
- Any return of `s` to the old level during WAIT restarts the qualification from zero. The next qualification needs a full STABLE_CYCLES again.
- STABLE_CYCLES=1: a value must be seen on two consecutive FSM edges (the WAIT-entry edge plus one).
- Reset mid-WAIT: qualification aborts, no pulse is emitted, `btn_out`=0.
- `btn_in` held 1 through reset release: treated as a normal press, so `btn_rise` fires after the full latency.
- Pulses are single-cycle even if `btn_in` stays stable indefinitely afterwards.

## Configuration
- `BTN_DEBOUNCE_SYNC_EN` defined:
  - `s` comes from a two-flop synchroniser, both flops reset to 0.
  - This is the mandatory setting for real pin inputs.
- Not defined:
  - `s` comes from a single sampling flop (reset 0), one cycle less latency.
  - Used only for simulation with `btn_in` already synchronous to `clk`.
- No other behaviour differs.

## Test plan
Bench uses STABLE_CYCLES=4 and the macro defined; stimulus changes on the falling edge of `clk`.
- Clean press: `btn_in` 0->1 before edge 10, held -> `btn_out`=1 from edge 16. `btn_rise`=1 for exactly the cycle after edge 16; `btn_fall` stays 0.
- Bounce rejection: `btn_in` high for 3 cycles, low for 1, repeated 5 times, then low -> `btn_out` stays 0 and no pulses occur.
- Bounce then settle: 1-cycle glitch, then `btn_in`=1 held from edge 20 -> `btn_out`=1 from edge 26, single `btn_rise`.
- Release: from the settled high state, `btn_in`=0 from edge 40 -> `btn_out`=0 from edge 46, single `btn_fall`, `btn_rise` stays 0.
- Reset mid-WAIT: `rst` pulsed while `cnt`=2 in `WAIT_HI`.
  - Required: all outputs 0 immediately (async), no pulse.
  - `btn_in` still 1 after release -> `btn_rise` appears 6 edges after the first post-reset edge.
- Build without the macro: repeat the clean press -> `btn_out`=1 from edge 15.
